// File: rtl/modexp_sequencer_if.sv
// Bundle of the request/response signals of modexp_sequencer and its link to the
// shared modular multiplier. The slave modport is the sequencer's view.
interface modexp_sequencer_if #(
  parameter int W  = 16,
  parameter int EW = 16
);
  logic          start;
  logic [W-1:0]  base;
  logic [EW-1:0] exp;
  logic [W-1:0]  n;
  logic          ct_mode;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  result;
  logic [31:0]   cycles;
  logic [15:0]   mul_ops;
  logic          mm_start;
  logic [W-1:0]  mm_a;
  logic [W-1:0]  mm_b;
  logic [W-1:0]  mm_n;
  logic          mm_done;
  logic [W-1:0]  mm_p;

  modport slave (
    input  start, base, exp, n, ct_mode, mm_done, mm_p,
    output busy, done, err, result, cycles, mul_ops, mm_start, mm_a, mm_b, mm_n
  );

  modport master (
    output start, base, exp, n, ct_mode, mm_done, mm_p,
    input  busy, done, err, result, cycles, mul_ops, mm_start, mm_a, mm_b, mm_n
  );
endinterface

// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply controller driving an external modular multiplier,
// with a selectable constant-time schedule and exported cycle/operation counters.
module modexp_sequencer #(
  parameter int W  = 16,
  parameter int EW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  modexp_sequencer_if.slave bus
);
  localparam int IW = (EW > 1) ? $clog2(EW) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CHECK   = 3'd1;
  localparam logic [2:0] SQ_REQ  = 3'd2;
  localparam logic [2:0] SQ_WAIT = 3'd3;
  localparam logic [2:0] MU_REQ  = 3'd4;
  localparam logic [2:0] MU_WAIT = 3'd5;
  localparam logic [2:0] FIN     = 3'd6;

  localparam logic [W-1:0]  ZERO_W  = {W{1'b0}};
  localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] ZERO_I  = {IW{1'b0}};
  localparam logic [IW-1:0] ONE_I   = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [31:0]   CYC_MAX = 32'hFFFF_FFFF;
  localparam logic [15:0]   OPS_MAX = 16'hFFFF;

  logic [2:0]    state_r, state_nxt;
  logic [W-1:0]  base_r, n_r, acc_r, acc_nxt;
  logic [EW-1:0] exp_r;
  logic          ct_r;
  logic [IW-1:0] idx_r, idx_nxt;
  logic          busy_r, done_r, err_r, err_nxt;
  logic [W-1:0]  result_r, result_nxt;
  logic [31:0]   cycles_r;
  logic [15:0]   mul_ops_r;
  logic          mm_start_r, mm_start_nxt;
  logic [W-1:0]  mm_a_r, mm_a_nxt, mm_b_r, mm_b_nxt, mm_n_r;
  logic          step_s;
  logic [W-1:0]  step_acc_s;

  // Position of the highest set exponent bit (0 when the exponent is zero).
  function automatic logic [IW-1:0] msb_pos(input logic [EW-1:0] e);
    logic [IW-1:0] p;
    p = ZERO_I;
    for (int k = 0; k < EW; k++) begin
      if (e[k]) p = IW'(k);
    end
    return p;
  endfunction

  // Next-state, accumulator and multiplier-request decode.
  always_comb begin
    state_nxt    = state_r;
    acc_nxt      = acc_r;
    idx_nxt      = idx_r;
    result_nxt   = result_r;
    err_nxt      = err_r;
    mm_start_nxt = 1'b0;
    mm_a_nxt     = mm_a_r;
    mm_b_nxt     = mm_b_r;
    step_s       = 1'b0;
    step_acc_s   = acc_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_nxt = CHECK;
        else           state_nxt = IDLE;
      end
      CHECK: begin
        if (n_r == ZERO_W || base_r >= n_r) begin
          err_nxt    = 1'b1;
          result_nxt = ZERO_W;
          state_nxt  = FIN;
        end else if (n_r == ONE_W) begin
          result_nxt = ZERO_W;
          state_nxt  = FIN;
        end else begin
          acc_nxt = ONE_W;
          idx_nxt = ct_r ? IW'(EW - 1) : msb_pos(exp_r);
          if (!ct_r && exp_r == {EW{1'b0}}) begin
            result_nxt = ONE_W;
            state_nxt  = FIN;
          end else begin
            state_nxt    = SQ_REQ;
            mm_start_nxt = 1'b1;
            mm_a_nxt     = ONE_W;
            mm_b_nxt     = ONE_W;
          end
        end
      end
      SQ_REQ:  state_nxt = SQ_WAIT;
      SQ_WAIT: begin
        if (bus.mm_done) begin
          acc_nxt = bus.mm_p;
          if (exp_r[idx_r] || ct_r) begin
            state_nxt    = MU_REQ;
            mm_start_nxt = 1'b1;
            mm_a_nxt     = bus.mm_p;
            mm_b_nxt     = base_r;
          end else begin
            step_s     = 1'b1;
            step_acc_s = bus.mm_p;
          end
        end else begin
          state_nxt = SQ_WAIT;
        end
      end
      MU_REQ:  state_nxt = MU_WAIT;
      MU_WAIT: begin
        if (bus.mm_done) begin
          // Constant-time dummy multiplies are issued but their product is dropped.
          step_s     = 1'b1;
          step_acc_s = exp_r[idx_r] ? bus.mm_p : acc_r;
          acc_nxt    = step_acc_s;
        end else begin
          state_nxt = MU_WAIT;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (step_s) begin
      if (idx_r == ZERO_I) begin
        result_nxt = step_acc_s;
        state_nxt  = FIN;
      end else begin
        idx_nxt      = idx_r - ONE_I;
        state_nxt    = SQ_REQ;
        mm_start_nxt = 1'b1;
        mm_a_nxt     = step_acc_s;
        mm_b_nxt     = step_acc_s;
      end
    end else begin
      step_acc_s = step_acc_s;
    end
  end

  // State, operand capture, registered outputs and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      base_r     <= ZERO_W;
      exp_r      <= {EW{1'b0}};
      n_r        <= ZERO_W;
      ct_r       <= 1'b0;
      acc_r      <= ZERO_W;
      idx_r      <= ZERO_I;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      result_r   <= ZERO_W;
      cycles_r   <= 32'd0;
      mul_ops_r  <= 16'd0;
      mm_start_r <= 1'b0;
      mm_a_r     <= ZERO_W;
      mm_b_r     <= ZERO_W;
      mm_n_r     <= ZERO_W;
    end else begin
      state_r    <= state_nxt;
      acc_r      <= acc_nxt;
      idx_r      <= idx_nxt;
      busy_r     <= (state_nxt != IDLE);
      done_r     <= (state_nxt == FIN);
      result_r   <= result_nxt;
      mm_start_r <= mm_start_nxt;
      mm_a_r     <= mm_a_nxt;
      mm_b_r     <= mm_b_nxt;
      if (state_r == IDLE && bus.start) begin
        base_r    <= bus.base;
        exp_r     <= bus.exp;
        n_r       <= bus.n;
        ct_r      <= bus.ct_mode;
        mm_n_r    <= bus.n;
        err_r     <= 1'b0;
        cycles_r  <= 32'd1;
        mul_ops_r <= 16'd0;
      end else begin
        err_r <= err_nxt;
        // The count seen in any busy cycle already includes that cycle.
        if (state_nxt != IDLE && cycles_r != CYC_MAX) cycles_r <= cycles_r + 32'd1;
        else                                           cycles_r <= cycles_r;
        if ((state_r == SQ_REQ || state_r == MU_REQ) && mul_ops_r != OPS_MAX)
          mul_ops_r <= mul_ops_r + 16'd1;
        else
          mul_ops_r <= mul_ops_r;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.result   = result_r;
  assign bus.cycles   = cycles_r;
  assign bus.mul_ops  = mul_ops_r;
  assign bus.mm_start = mm_start_r;
  assign bus.mm_a     = mm_a_r;
  assign bus.mm_b     = mm_b_r;
  assign bus.mm_n     = mm_n_r;
endmodule

// File: tb/tb_modexp_sequencer.sv
// Directed and randomised-latency bench for modexp_sequencer with a behavioural
// modular multiplier and a golden modexp reference.
module tb_modexp_sequencer;
  logic clk = 1'b0;
  logic rst_n;

  modexp_sequencer_if #(.W(16), .EW(16)) bus ();

  modexp_sequencer #(.W(16), .EW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int unsigned lat_sum      = 0;
  int unsigned stab_errs    = 0;
  int unsigned fixed_lat    = 1;
  bit          rand_lat     = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] ref_modexp(input logic [15:0] b, input logic [15:0] e,
                                             input logic [15:0] m);
    logic [63:0] r;
    if (m == 16'd0 || b >= m || m == 16'd1) return 16'd0;
    r = 64'd1;
    for (int i = 15; i >= 0; i--) begin
      r = (r * r) % 64'(m);
      if (e[i]) r = (r * 64'(b)) % 64'(m);
    end
    return r[15:0];
  endfunction

  function automatic int ref_ops(input logic [15:0] e, input bit ct);
    int bl, pc;
    bl = 0;
    pc = 0;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) begin
        bl = i + 1;
        pc++;
      end
    end
    return ct ? 32 : bl + pc;
  endfunction

  // Behavioural multiplier: answers each request after a fixed or random latency.
  initial begin : mult_model
    logic [15:0] ca, cb, cn;
    int unsigned lat;
    bus.mm_done = 1'b0;
    bus.mm_p    = 16'd0;
    @(posedge clk); #1;
    forever begin
      if (bus.mm_start && rst_n) begin
        ca  = bus.mm_a;
        cb  = bus.mm_b;
        cn  = bus.mm_n;
        lat = rand_lat ? $urandom_range(5, 1) : fixed_lat;
        lat_sum += lat;
        for (int j = 0; j < int'(lat); j++) begin
          @(posedge clk); #1;
          if (bus.busy && (bus.mm_a !== ca || bus.mm_b !== cb || bus.mm_n !== cn)) stab_errs++;
        end
        bus.mm_p    = (cn == 16'd0) ? 16'd0 : 16'((32'(ca) * 32'(cb)) % 32'(cn));
        bus.mm_done = 1'b1;
        @(posedge clk); #1;
        bus.mm_done = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // Runs one operation; called and returns #1 after a rising edge with the DUT idle.
  task automatic run_and_check(input string tag, input logic [15:0] b, input logic [15:0] e,
                               input logic [15:0] m, input bit ct, input logic [15:0] exp_res,
                               input bit exp_err, input int exp_ops, input int exp_cyc,
                               input bit cyc_from_lat, input bit spur);
    bit got;
    int want_cyc;
    got         = 1'b0;
    lat_sum     = 0;
    bus.base    = b;
    bus.exp     = e;
    bus.n       = m;
    bus.ct_mode = ct;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (spur && k == 2) begin
        bus.base  = 16'd2;
        bus.exp   = 16'd5;
        bus.start = 1'b1;
      end
      if (spur && k == 3) bus.start = 1'b0;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      want_cyc = cyc_from_lat ? 2 + exp_ops + int'(lat_sum) : exp_cyc;
      check_eq({tag, "_result"},  64'(bus.result),  64'(exp_res));
      check_eq({tag, "_err"},     64'(bus.err),     64'(exp_err));
      check_eq({tag, "_mul_ops"}, 64'(bus.mul_ops), 64'(exp_ops));
      check_eq({tag, "_cycles"},  64'(bus.cycles),  64'(want_cyc));
      @(posedge clk); #1;
      check_eq({tag, "_idle_after"}, 64'({bus.done, bus.busy}), 64'd0);
    end
  endtask

  initial begin : main
    logic [15:0] rb, re, rm;
    bit          rc;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.base    = 16'd0;
    bus.exp     = 16'd0;
    bus.n       = 16'd0;
    bus.ct_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_flags", 64'({bus.busy, bus.done, bus.err, bus.mm_start}), 64'd0);
    check_eq("reset_data", 64'({bus.result, bus.mm_a, bus.mm_b, bus.mm_n}), 64'd0);
    check_eq("reset_counters", {bus.cycles, 16'd0, bus.mul_ops}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Abort mid-run while the first square is outstanding.
    fixed_lat   = 4;
    bus.base    = 16'd1394;
    bus.exp     = 16'd2011;
    bus.n       = 16'd3127;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrun_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrun_rst_flags", 64'({bus.busy, bus.done, bus.err, bus.mm_start}), 64'd0);
    check_eq("midrun_rst_data", 64'({bus.result, bus.mm_a, bus.mm_b, bus.mm_n}), 64'd0);
    check_eq("midrun_rst_counters", {bus.cycles, 16'd0, bus.mul_ops}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("stray_done_ignored",
             64'({bus.busy, bus.done, bus.mm_start, bus.cycles}), 64'd0);
    fixed_lat = 1;

    run_and_check("enc_leaky",   16'd89,   16'd3,     16'd3127, 1'b0, 16'd1394, 1'b0, 4,  10, 1'b0, 1'b0);
    run_and_check("dec_leaky",   16'd1394, 16'd2011,  16'd3127, 1'b0, 16'd89,   1'b0, 20, 42, 1'b0, 1'b0);
    run_and_check("enc_ct",      16'd89,   16'd3,     16'd3127, 1'b1, 16'd1394, 1'b0, 32, 66, 1'b0, 1'b0);
    run_and_check("dec_ct",      16'd1394, 16'd2011,  16'd3127, 1'b1, 16'd89,   1'b0, 32, 66, 1'b0, 1'b0);
    run_and_check("base_eq_n",   16'd3127, 16'd5,     16'd3127, 1'b0, 16'd0,    1'b1, 0,  2,  1'b0, 1'b0);
    run_and_check("n_zero",      16'd5,    16'd7,     16'd0,    1'b0, 16'd0,    1'b1, 0,  2,  1'b0, 1'b0);
    run_and_check("n_one",       16'd0,    16'd7,     16'd1,    1'b0, 16'd0,    1'b0, 0,  2,  1'b0, 1'b0);
    run_and_check("exp_zero",    16'd7,    16'd0,     16'd3127, 1'b0, 16'd1,    1'b0, 0,  2,  1'b0, 1'b0);
    run_and_check("exp_zero_ct", 16'd7,    16'd0,     16'd3127, 1'b1, 16'd1,    1'b0, 32, 66, 1'b0, 1'b0);
    run_and_check("minus_one",   16'd3126, 16'hFFFF,  16'd3127, 1'b0, 16'd3126, 1'b0, 32, 66, 1'b0, 1'b0);

    rand_lat = 1'b1;
    for (int t = 0; t < 8; t++) begin
      rm = 16'($urandom_range(65535, 2));
      rb = 16'($urandom % 32'(rm));
      re = 16'($urandom_range(65535, 1));
      rc = (t % 2) == 1;
      run_and_check($sformatf("rand%0d", t), rb, re, rm, rc, ref_modexp(rb, re, rm), 1'b0,
                    ref_ops(re, rc), 0, 1'b1, 1'b1);
    end
    check_eq("mm_operands_stable", 64'(stab_errs), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
